// File: rtl/rob_retire_ctrl_if.sv
// Bundles the queue, writeback, register-file and redirect signals of the retire controller.
interface rob_retire_ctrl_if #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned VAL_W  = 32,
  parameter int unsigned ADDR_W = 4
);
  localparam int unsigned ENTRY_W = VAL_W + REG_W + 2;

  // queue consumer side
  logic [ENTRY_W-1:0] q_head_data;
  logic               q_empty;
  logic               q_pop;
  logic               q_flush;
  logic [ADDR_W-1:0]  q_probe_idx;
  logic [ENTRY_W-1:0] q_probe_rdata;
  logic               q_probe_we;
  logic [ENTRY_W-1:0] q_probe_wdata;
  // writeback results
  logic               wb_valid;
  logic [ADDR_W-1:0]  wb_idx;
  logic [VAL_W-1:0]   wb_value;
  logic               wb_mispredict;
  // architectural state update and fetch redirect
  logic               rf_we;
  logic [REG_W-1:0]   rf_addr;
  logic [VAL_W-1:0]   rf_data;
  logic               redirect_valid;
  logic [VAL_W-1:0]   redirect_target;
  logic [31:0]        retire_count;

  // retire controller side
  modport master (
    input  q_head_data, q_empty, q_probe_rdata,
    input  wb_valid, wb_idx, wb_value, wb_mispredict,
    output q_pop, q_flush, q_probe_idx, q_probe_we, q_probe_wdata,
    output rf_we, rf_addr, rf_data, redirect_valid, redirect_target, retire_count
  );

  // queue / pipeline / register-file side
  modport slave (
    output q_head_data, q_empty, q_probe_rdata,
    output wb_valid, wb_idx, wb_value, wb_mispredict,
    input  q_pop, q_flush, q_probe_idx, q_probe_we, q_probe_wdata,
    input  rf_we, rf_addr, rf_data, redirect_valid, redirect_target, retire_count
  );
endinterface

// File: rtl/rob_retire_ctrl.sv
// In-order retire controller on the consumer end of the reorder-buffer queue.
module rob_retire_ctrl #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned VAL_W  = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic clk,
  input  logic reset,
  rob_retire_ctrl_if.master bus
);
  localparam int unsigned ENTRY_W = VAL_W + REG_W + 2;
  // selects the dest field, which the writeback read-modify-write keeps
  localparam logic [ENTRY_W-1:0] DEST_MASK = {VAL_W'(0), {REG_W{1'b1}}, 2'b00};

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_retire_count;
  logic [31:0]        w_count_nxt;

  logic               w_head_done;
  logic               w_head_misp;
  logic [REG_W-1:0]   w_head_dest;
  logic [VAL_W-1:0]   w_head_value;
  logic [ENTRY_W-1:0] w_probe_wdata;

  assign w_head_done   = bus.q_head_data[0];
  assign w_head_misp   = bus.q_head_data[1];
  assign w_head_dest   = bus.q_head_data[REG_W+1:2];
  assign w_head_value  = bus.q_head_data[ENTRY_W-1:REG_W+2];
  assign w_probe_wdata = (bus.q_probe_rdata & DEST_MASK)
                       | {bus.wb_value, REG_W'(0), bus.wb_mispredict, 1'b1};

  assign bus.retire_count = r_retire_count;

  // State and retire counter; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_RUN;
      r_retire_count <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_retire_count <= w_count_nxt;
    end
  end

  // Next state and combinational outputs; everything reads zero while in reset.
  always_comb begin
    w_state_nxt         = r_state;
    w_count_nxt         = r_retire_count;
    bus.q_pop           = 1'b0;
    bus.q_flush         = 1'b0;
    bus.q_probe_idx     = '0;
    bus.q_probe_we      = 1'b0;
    bus.q_probe_wdata   = '0;
    bus.rf_we           = 1'b0;
    bus.rf_addr         = '0;
    bus.rf_data         = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    if (reset) begin
      bus.q_probe_idx = bus.wb_idx;
      case (r_state)
        ST_RUN: begin
          bus.q_probe_we    = bus.wb_valid;
          bus.q_probe_wdata = w_probe_wdata;
          if (!bus.q_empty && w_head_done) begin
            bus.q_pop   = 1'b1;
            bus.rf_we   = (w_head_dest != '0);
            bus.rf_addr = w_head_dest;
            bus.rf_data = w_head_value;
            w_count_nxt = r_retire_count + 32'd1;
            if (w_head_misp) begin
              bus.q_flush         = 1'b1;
              bus.redirect_valid  = 1'b1;
              bus.redirect_target = w_head_value;
              w_state_nxt         = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // single dead cycle while the queue settles empty after the flush
          w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Bench for rob_retire_ctrl: a behavioural queue plus a program-order scoreboard.
module tb_rob_retire_ctrl;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned VAL_W   = 32;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned ENTRY_W = VAL_W + REG_W + 2;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rob_retire_ctrl_if #(.REG_W(REG_W), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) bus ();
  rob_retire_ctrl #(.REG_W(REG_W), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- circular queue environment ----------------
  logic [ENTRY_W-1:0] q_mem [DEPTH];
  logic [ADDR_W-1:0]  q_head = '0;
  logic [ADDR_W-1:0]  q_tail = '0;
  int                 q_cnt  = 0;
  logic               push_en;
  logic [REG_W-1:0]   push_dest;

  assign bus.q_head_data   = q_mem[q_head];
  assign bus.q_empty       = (q_cnt == 0);
  assign bus.q_probe_rdata = q_mem[bus.q_probe_idx];

  always @(posedge clk) begin : env_q
    int c;
    c = q_cnt;
    if (bus.q_flush) begin
      q_head <= '0;
      q_tail <= '0;
      q_cnt  <= 0;
    end else begin
      if (bus.q_probe_we) q_mem[bus.q_probe_idx] <= bus.q_probe_wdata;
      if (bus.q_pop) begin q_head <= q_head + 1'b1; c = c - 1; end
      if (push_en) begin
        q_mem[q_tail] <= {VAL_W'(0), push_dest, 2'b00};
        q_tail <= q_tail + 1'b1;
        c = c + 1;
      end
      q_cnt <= c;
    end
  end

  // ---------------- reference model: entries in program order ----------------
  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [REG_W-1:0]  dest;
    logic [VAL_W-1:0]  value;
    bit                done;
    bit                misp;
  } ent_t;

  typedef struct packed {
    logic             pop;
    logic             flush;
    logic             probe_we;
    logic             rf_we;
    logic [REG_W-1:0] rf_addr;
    logic [VAL_W-1:0] rf_data;
    logic             redirect;
    logic [VAL_W-1:0] target;
  } exp_t;

  ent_t              m_q[$];
  logic [ADDR_W-1:0] m_push_ptr = '0;
  bit                m_drain    = 1'b0;
  logic [31:0]       m_count    = '0;

  // What the controller should do this cycle, from the program-order view.
  function automatic exp_t predict();
    exp_t e;
    e = '0;
    if (reset && !m_drain) begin
      e.probe_we = bus.wb_valid;
      if (m_q.size() > 0 && m_q[0].done) begin
        e.pop      = 1'b1;
        e.rf_we    = (m_q[0].dest != '0);
        e.rf_addr  = m_q[0].dest;
        e.rf_data  = m_q[0].value;
        e.flush    = m_q[0].misp;
        e.redirect = m_q[0].misp;
        e.target   = m_q[0].value;
      end
    end
    return e;
  endfunction

  // Advance one clock edge and apply the cycle's effects to the model.
  task automatic tick(input exp_t e);
    @(posedge clk); #1;
    if (e.probe_we)
      foreach (m_q[k])
        if (m_q[k].idx == bus.wb_idx) begin
          m_q[k].done  = 1'b1;
          m_q[k].value = bus.wb_value;
          m_q[k].misp  = bus.wb_mispredict;
        end
    if (e.pop) begin void'(m_q.pop_front()); m_count = m_count + 32'd1; end
    if (push_en) begin
      m_q.push_back('{idx: m_push_ptr, dest: push_dest, value: '0, done: 1'b0, misp: 1'b0});
      m_push_ptr = m_push_ptr + 1'b1;
    end
    if (e.flush) begin m_q.delete(); m_push_ptr = '0; end
    m_drain = reset && e.flush;
    if (!reset) m_count = '0;
  endtask

  task automatic set_idle();
    push_en           = 1'b0;
    push_dest         = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_idx        = '0;
    bus.wb_value      = '0;
    bus.wb_mispredict = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      set_idle();
      bus.wb_valid = 1'b1; bus.wb_idx = ADDR_W'(cyc); bus.wb_value = $urandom;
      @(negedge clk); e = predict();
      n_checks++;
      if ({bus.q_pop, bus.q_flush, bus.q_probe_we, bus.rf_we, bus.redirect_valid} !== 5'b0)
        $display("FAIL reset_ctrl cyc%0d: got %b expected 00000", cyc,
                 {bus.q_pop, bus.q_flush, bus.q_probe_we, bus.rf_we, bus.redirect_valid});
      else n_pass++;
      n_checks++;
      if ({bus.rf_addr, bus.rf_data, bus.redirect_target, bus.q_probe_wdata, bus.q_probe_idx} !== '0)
        $display("FAIL reset_buses cyc%0d: got nonzero data bus, expected all zero", cyc);
      else n_pass++;
      if (cyc > 0) begin
        n_checks++;
        if (bus.retire_count !== 32'd0)
          $display("FAIL reset_count cyc%0d: got %0d expected 0", cyc, bus.retire_count);
        else n_pass++;
      end
      tick(e);
    end
    n_checks++;
    if (q_cnt !== 0) $display("FAIL reset_no_queue_change: got count %0d expected 0", q_cnt);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_single_retire();
    exp_t e; logic [ADDR_W-1:0] base; logic [31:0] c0;
    base = m_push_ptr; c0 = m_count;
    for (int cyc = 0; cyc < 7; cyc++) begin
      set_idle();
      if (cyc == 0) begin push_en = 1'b1; push_dest = 5'd3; end
      if (cyc == 5) begin bus.wb_valid = 1'b1; bus.wb_idx = base; bus.wb_value = 32'hDEADBEEF; end
      @(negedge clk); e = predict();
      if (cyc >= 1 && cyc <= 5) begin
        n_checks++;
        if (bus.q_pop !== 1'b0) $display("FAIL single_no_early_pop cyc%0d: got %b expected 0", cyc, bus.q_pop);
        else n_pass++;
      end
      if (cyc == 5) begin
        n_checks++;
        if ({bus.q_probe_we, bus.q_probe_wdata} !== {1'b1, 32'hDEADBEEF, 5'd3, 2'b01})
          $display("FAIL single_probe: got %b/%h expected 1/%h", bus.q_probe_we, bus.q_probe_wdata,
                   {32'hDEADBEEF, 5'd3, 2'b01});
        else n_pass++;
      end
      if (cyc == 6) begin
        n_checks++;
        if ({bus.q_pop, bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 1'b1, 5'd3, 32'hDEADBEEF})
          $display("FAIL single_retire: got pop=%b we=%b addr=%0d data=%h expected 1 1 3 deadbeef",
                   bus.q_pop, bus.rf_we, bus.rf_addr, bus.rf_data);
        else n_pass++;
      end
      tick(e);
    end
    n_checks++;
    if (bus.retire_count !== c0 + 32'd1)
      $display("FAIL single_count: got %0d expected %0d", bus.retire_count, c0 + 32'd1);
    else n_pass++;
  endtask

  task automatic test_out_of_order();
    exp_t e; logic [ADDR_W-1:0] base; logic [31:0] c0;
    logic [REG_W-1:0] dests [3];
    logic [VAL_W-1:0] vals [3];
    base = m_push_ptr; c0 = m_count;
    dests[0] = 5'd1; dests[1] = 5'd2; dests[2] = 5'd0;
    for (int k = 0; k < 3; k++) vals[k] = $urandom;
    for (int cyc = 0; cyc < 9; cyc++) begin
      set_idle();
      if (cyc < 3) begin push_en = 1'b1; push_dest = dests[cyc]; end
      if (cyc >= 3 && cyc < 6) begin
        bus.wb_valid = 1'b1;
        bus.wb_idx   = ADDR_W'(base + ADDR_W'(5 - cyc));
        bus.wb_value = vals[5 - cyc];
      end
      @(negedge clk); e = predict();
      if (cyc >= 3 && cyc < 6) begin
        n_checks++;
        if (bus.q_pop !== 1'b0) $display("FAIL ooo_wait cyc%0d: got pop %b expected 0", cyc, bus.q_pop);
        else n_pass++;
      end
      if (cyc >= 6) begin
        n_checks++;
        if ({bus.q_pop, bus.rf_we} !== {1'b1, dests[cyc-6] != 5'd0} ||
            (dests[cyc-6] != 5'd0 && {bus.rf_addr, bus.rf_data} !== {dests[cyc-6], vals[cyc-6]}))
          $display("FAIL ooo_retire%0d: got pop=%b we=%b addr=%0d data=%h expected 1 %b %0d %h", cyc-6,
                   bus.q_pop, bus.rf_we, bus.rf_addr, bus.rf_data, dests[cyc-6] != 5'd0,
                   dests[cyc-6], vals[cyc-6]);
        else n_pass++;
      end
      tick(e);
    end
    n_checks++;
    if (bus.retire_count !== c0 + 32'd3 || bus.q_empty !== 1'b1)
      $display("FAIL ooo_count: got %0d empty=%b expected %0d empty=1", bus.retire_count, bus.q_empty, c0 + 32'd3);
    else n_pass++;
  endtask

  task automatic test_mispredict();
    exp_t e; logic [ADDR_W-1:0] base; logic [31:0] c0;
    base = m_push_ptr; c0 = m_count;
    for (int cyc = 0; cyc < 6; cyc++) begin
      set_idle();
      if (cyc < 3) begin push_en = 1'b1; push_dest = (cyc == 0) ? 5'd0 : REG_W'(cyc + 4); end
      if (cyc == 3) begin
        bus.wb_valid = 1'b1; bus.wb_idx = base; bus.wb_value = 32'h400; bus.wb_mispredict = 1'b1;
      end
      if (cyc == 4) begin bus.wb_valid = 1'b1; bus.wb_idx = ADDR_W'(base + 1'b1); bus.wb_value = 32'h55; end
      if (cyc == 5) begin bus.wb_valid = 1'b1; bus.wb_idx = ADDR_W'(base + 2'd2); bus.wb_value = 32'h66; end
      @(negedge clk); e = predict();
      if (cyc == 3) begin
        n_checks++;
        if ({bus.q_pop, bus.q_flush} !== 2'b00) $display("FAIL misp_early: got %b expected 00", {bus.q_pop, bus.q_flush});
        else n_pass++;
      end
      if (cyc == 4) begin
        n_checks++;
        if ({bus.q_pop, bus.q_flush, bus.redirect_valid, bus.rf_we, bus.q_probe_we} !== 5'b11101 ||
            bus.redirect_target !== 32'h400)
          $display("FAIL misp_retire: got pop/flush/redir/we/probe=%b target=%h expected 11101 400",
                   {bus.q_pop, bus.q_flush, bus.redirect_valid, bus.rf_we, bus.q_probe_we}, bus.redirect_target);
        else n_pass++;
      end
      if (cyc == 5) begin
        n_checks++;
        if ({bus.q_pop, bus.q_flush, bus.redirect_valid, bus.rf_we, bus.q_probe_we} !== 5'b0)
          $display("FAIL misp_drain: got %b expected 00000",
                   {bus.q_pop, bus.q_flush, bus.redirect_valid, bus.rf_we, bus.q_probe_we});
        else n_pass++;
      end
      tick(e);
    end
    n_checks++;
    if (bus.q_empty !== 1'b1 || bus.retire_count !== c0 + 32'd1)
      $display("FAIL misp_after: got empty=%b count=%0d expected 1 %0d", bus.q_empty, bus.retire_count, c0 + 32'd1);
    else n_pass++;
  endtask

  task automatic test_wrap();
    exp_t e; logic [ADDR_W-1:0] base; logic [31:0] c0; int got;
    logic [REG_W-1:0] dests [10];
    logic [VAL_W-1:0] vals [10];
    base = m_push_ptr; c0 = m_count; got = 0;
    for (int k = 0; k < 10; k++) begin dests[k] = REG_W'($urandom_range(31, 1)); vals[k] = $urandom; end
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      set_idle();
      if (cyc < 10) begin push_en = 1'b1; push_dest = dests[cyc]; end
      if (cyc >= 1 && cyc <= 10) begin
        bus.wb_valid = 1'b1; bus.wb_idx = ADDR_W'(base + ADDR_W'(cyc - 1)); bus.wb_value = vals[cyc-1];
      end
      @(negedge clk); e = predict();
      if (bus.q_pop === 1'b1) begin
        n_checks++;
        if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, dests[got], vals[got]})
          $display("FAIL wrap_retire%0d: got we=%b addr=%0d data=%h expected 1 %0d %h", got,
                   bus.rf_we, bus.rf_addr, bus.rf_data, dests[got], vals[got]);
        else n_pass++;
        got++;
      end
      tick(e);
    end
    n_checks++;
    if (got != 10 || bus.retire_count !== c0 + 32'd10)
      $display("FAIL wrap_total: got %0d retires count=%0d expected 10 %0d", got, bus.retire_count, c0 + 32'd10);
    else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    exp_t e; logic [ADDR_W-1:0] base;
    base = m_push_ptr;
    for (int cyc = 0; cyc < 5; cyc++) begin
      set_idle();
      if (cyc == 0) begin push_en = 1'b1; push_dest = 5'd7; end
      if (cyc == 1) begin
        bus.wb_valid = 1'b1; bus.wb_idx = base; bus.wb_value = 32'h800; bus.wb_mispredict = 1'b1;
      end
      if (cyc == 3) reset = 1'b0;
      if (cyc == 4) begin reset = 1'b1; bus.wb_valid = 1'b1; bus.wb_idx = '0; bus.wb_value = 32'h1234; end
      @(negedge clk); e = predict();
      if (cyc == 2) begin
        n_checks++;
        if ({bus.q_flush, bus.rf_we, bus.rf_addr} !== {1'b1, 1'b1, 5'd7})
          $display("FAIL rstdrain_flush: got flush=%b we=%b addr=%0d expected 1 1 7", bus.q_flush, bus.rf_we, bus.rf_addr);
        else n_pass++;
      end
      if (cyc == 3) begin
        n_checks++;
        if ({bus.q_pop, bus.q_flush, bus.q_probe_we, bus.rf_we, bus.redirect_valid} !== 5'b0)
          $display("FAIL rstdrain_hold: got %b expected 00000",
                   {bus.q_pop, bus.q_flush, bus.q_probe_we, bus.rf_we, bus.redirect_valid});
        else n_pass++;
      end
      if (cyc == 4) begin
        n_checks++;
        if ({bus.retire_count, bus.q_flush, bus.q_probe_we} !== {32'd0, 1'b0, 1'b1})
          $display("FAIL rstdrain_run: got count=%0d flush=%b probe_we=%b expected 0 0 1",
                   bus.retire_count, bus.q_flush, bus.q_probe_we);
        else n_pass++;
      end
      tick(e);
    end
  endtask

  task automatic test_random();
    exp_t e; int cand[$]; int k; bit found; logic [REG_W-1:0] pdest;
    for (int cyc = 0; cyc < 300; cyc++) begin
      set_idle();
      reset = ($urandom_range(99) != 0);
      if (m_q.size() < DEPTH && $urandom_range(99) < 60) begin push_en = 1'b1; push_dest = REG_W'($urandom); end
      cand.delete();
      foreach (m_q[j]) if (!m_q[j].done) cand.push_back(j);
      if (cand.size() > 0 && $urandom_range(99) < 55) begin
        k = cand[$urandom_range(cand.size() - 1)];
        bus.wb_valid      = 1'b1;
        bus.wb_idx        = m_q[k].idx;
        bus.wb_value      = $urandom;
        bus.wb_mispredict = ($urandom_range(9) == 0);
      end
      @(negedge clk); e = predict();
      n_checks++;
      if ({bus.q_pop, bus.q_flush, bus.q_probe_we, bus.rf_we, bus.redirect_valid} !==
          {e.pop, e.flush, e.probe_we, e.rf_we, e.redirect})
        $display("FAIL rand_ctrl cyc%0d: got %b expected %b", cyc,
                 {bus.q_pop, bus.q_flush, bus.q_probe_we, bus.rf_we, bus.redirect_valid},
                 {e.pop, e.flush, e.probe_we, e.rf_we, e.redirect});
      else n_pass++;
      if (e.rf_we) begin
        n_checks++;
        if ({bus.rf_addr, bus.rf_data} !== {e.rf_addr, e.rf_data})
          $display("FAIL rand_rf cyc%0d: got %0d/%h expected %0d/%h", cyc, bus.rf_addr, bus.rf_data, e.rf_addr, e.rf_data);
        else n_pass++;
      end
      if (e.redirect) begin
        n_checks++;
        if (bus.redirect_target !== e.target)
          $display("FAIL rand_target cyc%0d: got %h expected %h", cyc, bus.redirect_target, e.target);
        else n_pass++;
      end
      if (e.probe_we) begin
        found = 1'b0; pdest = '0;
        foreach (m_q[j]) if (m_q[j].idx == bus.wb_idx) begin found = 1'b1; pdest = m_q[j].dest; end
        if (found) begin
          n_checks++;
          if ({bus.q_probe_idx, bus.q_probe_wdata} !== {bus.wb_idx, bus.wb_value, pdest, bus.wb_mispredict, 1'b1})
            $display("FAIL rand_probe cyc%0d: got idx=%0d data=%h expected idx=%0d data=%h", cyc,
                     bus.q_probe_idx, bus.q_probe_wdata, bus.wb_idx,
                     {bus.wb_value, pdest, bus.wb_mispredict, 1'b1});
          else n_pass++;
        end
      end
      n_checks++;
      if (bus.retire_count !== m_count)
        $display("FAIL rand_count cyc%0d: got %0d expected %0d", cyc, bus.retire_count, m_count);
      else n_pass++;
      tick(e);
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    test_reset();
    test_single_retire();
    test_out_of_order();
    test_mispredict();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
